// File: rtl/mbist_pkg.sv
// mbist_pkg: shared FSM/op enums and the March C- element table for the BIST controller
package mbist_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;
  typedef enum logic {WR = 1'b0, RD = 1'b1} op_e;
  localparam int NUM_ELEM = 6;
  typedef struct packed {
    logic       up;
    logic [1:0] nops;
    op_e        first;
    logic       rbg;
    logic       wbg;
  } elem_t;
  function automatic elem_t elem_info(input logic [2:0] e);
    case (e)
      3'd0:    return '{up: 1'b1, nops: 2'd1, first: WR, rbg: 1'b0, wbg: 1'b0};
      3'd1:    return '{up: 1'b1, nops: 2'd2, first: RD, rbg: 1'b0, wbg: 1'b1};
      3'd2:    return '{up: 1'b1, nops: 2'd2, first: RD, rbg: 1'b1, wbg: 1'b0};
      3'd3:    return '{up: 1'b0, nops: 2'd2, first: RD, rbg: 1'b0, wbg: 1'b1};
      3'd4:    return '{up: 1'b0, nops: 2'd2, first: RD, rbg: 1'b1, wbg: 1'b0};
      default: return '{up: 1'b1, nops: 2'd1, first: RD, rbg: 1'b0, wbg: 1'b0};
    endcase
  endfunction
endpackage

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: up/down address counter with load to 0 or WCOUNT-1 and terminal flag
module mbist_addr_gen #(
  parameter int WCOUNT = 256,
  localparam int AW = $clog2(WCOUNT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          load_hi,
  input  logic          step,
  input  logic          down,
  output logic [AW-1:0] addr,
  output logic          last
);
  localparam logic [AW-1:0] TOP = AW'(WCOUNT - 1);
  always_ff @(posedge clk)
    if (rst) addr <= '0;
    else if (load) addr <= load_hi ? TOP : '0;
    else if (step) addr <= down ? addr - 1'b1 : addr + 1'b1;
  assign last = down ? (addr == '0) : (addr == TOP);
endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- BIST sequencer, RAM port mux and first-failure capture
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int WCOUNT = 256,
  parameter int WLENGTH = 4,
  localparam int AW = $clog2(WCOUNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               rwbarin,
  input  logic [WLENGTH-1:0] datain,
  input  logic [AW-1:0]      address,
  input  logic [WLENGTH-1:0] mem_dout,
  output logic               mem_rwbar,
  output logic [AW-1:0]      mem_addr,
  output logic [WLENGTH-1:0] mem_din,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [AW-1:0]      fail_addr,
  output logic [2:0]         fail_elem
);
  state_e state;
  logic [2:0] elem;
  logic op_idx;
  elem_t cur;
  op_e op;
  logic run, accept, last_op, elem_end, last_elem, nxt_up;
  logic [AW-1:0] ag_addr;
  logic ag_last;
  logic rd_vld, mismatch;
  logic [WLENGTH-1:0] exp_q;
  logic [AW-1:0] raddr;
  logic [2:0] relem;
  assign cur = elem_info(elem);
  assign nxt_up = elem_info(elem + 3'd1).up;
  assign op = op_idx ? WR : cur.first;
  assign run = state == RUN;
  assign accept = start && (state == IDLE || state == DONE);
  assign last_op = op_idx || cur.nops == 2'd1;
  assign last_elem = elem == 3'(NUM_ELEM - 1);
  assign elem_end = run && last_op && ag_last;
  mbist_addr_gen #(.WCOUNT(WCOUNT)) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (accept || (elem_end && !last_elem)),
    .load_hi (!accept && !nxt_up),
    .step    (run && last_op && !ag_last),
    .down    (!cur.up),
    .addr    (ag_addr),
    .last    (ag_last)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state  <= IDLE;
      elem   <= '0;
      op_idx <= 1'b0;
    end else begin
      state  <= accept ? RUN : (elem_end && last_elem) ? DRAIN : state == DRAIN ? DONE : state;
      elem   <= accept ? 3'd0 : (elem_end && !last_elem) ? elem + 3'd1 : elem;
      op_idx <= run && !last_op;
    end
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  // DRAIN issues a harmless read of address 0 while the last read is compared
  assign mem_rwbar = busy ? (!run || op == RD) : rwbarin;
  assign mem_addr  = busy ? (run ? ag_addr : '0) : address;
  assign mem_din   = busy ? {WLENGTH{cur.wbg}} : datain;
  assign mismatch = rd_vld && mem_dout != exp_q;
  always_ff @(posedge clk)
    if (rst) begin
      rd_vld    <= 1'b0;
      exp_q     <= '0;
      raddr     <= '0;
      relem     <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else begin
      rd_vld <= run && op == RD;
      exp_q  <= {WLENGTH{cur.rbg}};
      raddr  <= ag_addr;
      relem  <= elem;
      if (accept) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
      end else if (mismatch) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_addr <= raddr;
          fail_elem <= relem;
        end
      end
    end
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: scoreboard bench for the March C- BIST controller with fault-injecting RAM model
module tb_mbist_march_ctrl;
  localparam int N = 256;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rwbarin = 1'b1;
  logic [3:0] datain = '0, mem_dout;
  logic [7:0] address = '0;
  logic mem_rwbar, busy, done, fail;
  logic [7:0] mem_addr, fail_addr;
  logic [3:0] mem_din;
  logic [2:0] fail_elem;
  int passed = 0, total = 0, fault = 0;
  logic [3:0] ram [N];
  typedef struct {logic rd; logic [7:0] a; logic [3:0] d;} op_t;
  typedef struct {logic f; logic [7:0] a; logic [2:0] e;} res_t;
  op_t opq[$];
  res_t resq[$];

  always #5 clk = ~clk;

  mbist_march_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .rwbarin(rwbarin), .datain(datain),
    .address(address), .mem_dout(mem_dout), .mem_rwbar(mem_rwbar), .mem_addr(mem_addr),
    .mem_din(mem_din), .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .fail_elem(fail_elem)
  );

  initial for (int i = 0; i < N; i++) ram[i] = 4'h0;

  always @(posedge clk) begin
    if (!mem_rwbar)
      ram[mem_addr] <= {mem_din[3],
                        mem_din[2] & !(fault == 2 && mem_addr == 8'hFF && !ram[mem_addr][2]),
                        mem_din[1:0]};
    mem_dout <= ram[mem_addr] | ((fault == 1 && mem_addr == 8'h37) ? 4'h1 : 4'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ops();
    logic [7:0] a;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++) begin
        a = (e == 3 || e == 4) ? 8'(N - 1 - i) : 8'(i);
        case (e)
          0: opq.push_back('{1'b0, a, 4'h0});
          1, 3: begin opq.push_back('{1'b1, a, 4'h0}); opq.push_back('{1'b0, a, 4'hF}); end
          2, 4: begin opq.push_back('{1'b1, a, 4'hF}); opq.push_back('{1'b0, a, 4'h0}); end
          default: opq.push_back('{1'b1, a, 4'h0});
        endcase
      end
  endtask

  task automatic run_march(input string nm, input int flt, input int repulse, input int abort_at,
                           input logic ef, input logic [7:0] ea, input logic [2:0] ee);
    op_t op;
    res_t r;
    fault = flt;
    push_ops();
    resq.push_back('{ef, ea, ee});
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (done !== 1'b0 || fail !== 1'b0 || fail_addr !== 8'h0 || fail_elem !== 3'h0)
      $display("FAIL %s clear: done=%b fail=%b addr=%h elem=%0d, want 0 0 00 0", nm, done, fail, fail_addr, fail_elem);
    else passed++;
    for (int k = 1; k <= 10 * N; k++) begin
      rwbarin = 1'($urandom);
      datain = 4'($urandom);
      address = 8'($urandom);
      #1;
      op = opq.pop_front();
      total++;
      if (busy !== 1'b1 || mem_rwbar !== op.rd || mem_addr !== op.a || (!op.rd && mem_din !== op.d))
        $display("FAIL %s op%0d: busy=%b rwbar=%b addr=%h din=%h, want busy=1 rwbar=%b addr=%h din=%h",
                 nm, k, busy, mem_rwbar, mem_addr, mem_din, op.rd, op.a, op.d);
      else passed++;
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        opq.delete();
        resq.delete();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0 || fail_addr !== 8'h0 || fail_elem !== 3'h0 ||
            mem_rwbar !== rwbarin || mem_addr !== address || mem_din !== datain)
          $display("FAIL %s abort: busy=%b done=%b fail=%b addr=%h elem=%0d mem=%b/%h/%h, want 0 0 0 00 0 mem=%b/%h/%h",
                   nm, busy, done, fail, fail_addr, fail_elem, mem_rwbar, mem_addr, mem_din, rwbarin, address, datain);
        else passed++;
        return;
      end
      start = (k == repulse);
      tick();
      start = 1'b0;
    end
    #1;
    total++;
    if (busy !== 1'b1 || mem_rwbar !== 1'b1 || mem_addr !== 8'h0)
      $display("FAIL %s drain: busy=%b rwbar=%b addr=%h, want 1 1 00", nm, busy, mem_rwbar, mem_addr);
    else passed++;
    tick();
    r = resq.pop_front();
    total++;
    if (busy !== 1'b0 || done !== 1'b1 || fail !== r.f || fail_addr !== r.a || fail_elem !== r.e || mem_addr !== address)
      $display("FAIL %s result: busy=%b done=%b fail=%b addr=%h elem=%0d, want 0 1 %b %h %0d",
               nm, busy, done, fail, fail_addr, fail_elem, r.f, r.a, r.e);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0 || fail_addr !== 8'h0 || fail_elem !== 3'h0)
      $display("FAIL reset: busy=%b done=%b fail=%b addr=%h elem=%0d, want 0 0 0 00 0", busy, done, fail, fail_addr, fail_elem);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_pass_through();
    rwbarin = 1'b0; address = 8'h12; datain = 4'hA;
    #1;
    total++;
    if (mem_rwbar !== 1'b0 || mem_addr !== 8'h12 || mem_din !== 4'hA)
      $display("FAIL pass_wr: rwbar=%b addr=%h din=%h, want 0 12 a", mem_rwbar, mem_addr, mem_din);
    else passed++;
    rwbarin = 1'b1; address = 8'hC5; datain = 4'h3;
    #1;
    total++;
    if (mem_rwbar !== 1'b1 || mem_addr !== 8'hC5 || mem_din !== 4'h3)
      $display("FAIL pass_rd: rwbar=%b addr=%h din=%h, want 1 c5 3", mem_rwbar, mem_addr, mem_din);
    else passed++;
    tick();
  endtask

  task automatic test_start_with_reset();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL start_rst: busy=%b done=%b, want 0 0", busy, done);
    else passed++;
  endtask

  task automatic test_fault_free();   run_march("clean", 0, 0, 0, 1'b0, 8'h00, 3'd0); endtask
  task automatic test_stuck_at();     run_march("stuck", 1, 0, 0, 1'b1, 8'h37, 3'd1); endtask
  task automatic test_transition();   run_march("trans", 2, 0, 0, 1'b1, 8'hFF, 3'd2); endtask
  task automatic test_rerun();        run_march("rerun", 0, 500, 0, 1'b0, 8'h00, 3'd0); endtask
  task automatic test_back_to_back(); run_march("b2b", 0, 0, 0, 1'b0, 8'h00, 3'd0); endtask
  task automatic test_reset_mid_run();
    run_march("abort", 1, 0, 1000, 1'b0, 8'h00, 3'd0);
    tick();
    run_march("after_abort", 0, 0, 0, 1'b0, 8'h00, 3'd0);
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_start_with_reset();
    test_fault_free();
    test_stuck_at();
    test_transition();
    test_rerun();
    test_back_to_back();
    test_reset_mid_run();
    test_pass_through();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

March C- memory-BIST controller and port arbiter for the WCOUNT x WLENGTH single-port RAM.

- When idle, it passes the functional read/write port straight through to the RAM.
- On `start`, it takes over the RAM port and runs the 10N March C- sequence. It compares every read against the expected background and reports pass/fail plus the first failing address and element.
- It sits between the functional access logic and the RAM inside TOP, replacing counter-pattern test sequencing.

## Interface
- `WCOUNT`, default 256: number of RAM words; any value ≥ 2, not necessarily a power of two.
- `WLENGTH`, default 4: RAM word width.
- AW = `$clog2(WCOUNT)`: derived address width, not a parameter.

- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a BIST run; ignored while `busy`.
- `rwbarin`  in  1  functional access: 1 = read, 0 = write.
- `datain`  in  WLENGTH  functional write data.
- `address`  in  AW  functional address.
- `mem_dout`  in  WLENGTH  RAM read data; valid the cycle after the read address is presented.
- `mem_rwbar`  out  1  RAM read/write select: 1 = read, 0 = write.
- `mem_addr`  out  AW  RAM address.
- `mem_din`  out  WLENGTH  RAM write data.
- `busy`  out  1  BIST owns the RAM port.
- `done`  out  1  run complete; held until the next accepted `start` or reset.
- `fail`  out  1  sticky mismatch flag for the current or last run.
- `fail_addr`  out  AW  address of the first mismatch.
- `fail_elem`  out  3  March element index (0–5) of the first mismatch.

## Operation
- **Elements**, with backgrounds all-0 / all-1 over WLENGTH bits:
  - E0 ⇑ (w0)
  - E1 ⇑ (r0, w1)
  - E2 ⇑ (r1, w0)
  - E3 ⇓ (r0, w1)
  - E4 ⇓ (r1, w0)
  - E5 ⇑ (r0)
- ⇑ steps addresses 0 → WCOUNT−1; ⇓ steps WCOUNT−1 → 0. Terminal count is detected by compare against WCOUNT−1 or 0; there is no wrap past the terminal.
- **Op order:** all ops of an element are issued at one address before the address advances.
- **FSM:**
  - IDLE → RUN on `start`.
  - RUN → DRAIN after E5's last op.
  - DRAIN → DONE after one cycle.
  - DONE → RUN on `start`.
  - `rst` from any state → IDLE.
- **Port mux:** in IDLE/DONE, `mem_*` = functional inputs, combinationally. In RUN/DRAIN, `mem_*` come from the controller and functional inputs are ignored (no queuing). DRAIN drives a read of address 0.
- **Compare pipeline:** each read registers its expected value, address and element. In the next cycle, `mem_dout` is compared against the registered expected value. A mismatch sets `fail` the cycle after that.
- **First failure:** `fail_addr`/`fail_elem` latch on the first mismatch only. The run always continues to completion; there is no stop-on-fail.
- **Accepted `start`:** clears `done`, `fail`, `fail_addr` and `fail_elem`.
- **Reset values:** `busy`=0, `done`=0, `fail`=0, `fail_addr`=0, `fail_elem`=0, state IDLE, all address and element counters 0.

## Timing
- `start` sampled high in IDLE/DONE at edge t → first op (E0 w0 at address 0) on `mem_*` in cycle t+1; `busy`=1 from t+1.
- **Ops:** 10·WCOUNT, one per cycle, no bubbles, in cycles t+1 … t+10·WCOUNT. For WCOUNT=256: 2560 ops, t+1 … t+2560.
- **DRAIN:** cycle t+10·WCOUNT+1.
- **Completion:** at t+10·WCOUNT+2, `busy`=0, `done`=1, and `fail` is final in the same cycle.
- **Read latency:** read issued in cycle c → compared in c+1 → `fail` visible at c+2.
- **`start` during RUN/DRAIN:** no effect.
- **`start` coincident with `rst`:** reset wins.
- **`rst` mid-run:** the cycle after the reset edge, state is IDLE, all outputs are at reset values, and `mem_*` mirror the functional inputs. RAM contents are left as they are.

## Structure
- **Shared package `mbist_pkg`:**
  - state enum (IDLE, RUN, DRAIN, DONE);
  - op enum (RD, WR);
  - constant element table per index: direction, op count, read background, write background;
  - `NUM_ELEM` = 6.
- **Sub-module `mbist_addr_gen`:**
  - up/down AW-bit counter with load-start (0 or WCOUNT−1) and terminal flag;
  - instantiated once, driven by the FSM.
- Compare/capture logic and the port mux stay in `mbist_march_ctrl`.

## Test plan
1. **Fault-free run:** reset, fault-free RAM model, pulse `start` at t → `busy` high t+1 … t+2561; `done`=1 and `fail`=0 at t+2562.
2. **Stuck-at-1:** bit0 stuck at 1 at address 0x37 → `fail`=1, `fail_addr`=0x37, `fail_elem`=1. Run still completes at t+2562.
3. **Transition fault:** bit2 cannot make a 0→1 transition at address 0xFF → `fail_addr`=0xFF, `fail_elem`=2.
4. **Pass-through and isolation:**
   - Idle, `address`=0x12, `datain`=4'hA, `rwbarin`=0 → same-cycle `mem_addr`=0x12, `mem_din`=4'hA, `mem_rwbar`=0.
   - During `busy`, toggling the functional inputs does not change `mem_*`.
5. **Re-run:** `start` re-pulsed at cycle t+500 → ignored, completion still at t+2562. Second `start` after `done` → `done`/`fail` clear next cycle and a full run repeats.
6. **Reset mid-run:** `rst` at t+1000 → next cycle `busy`=0, `done`=0, `fail`=0, `mem_*` equal the functional inputs. A following `start` runs cleanly.
